// File: rtl/debug_trace_buffer_pkg.sv
// Shared types for the retire-trace capture block: record layout, capture mode
// and capture FSM states.
package debug_trace_buffer_pkg;

  // Recorded tick is held at a fixed width; the counter width is a parameter of the top.
  localparam int TRACE_TICK_W = 32;

  typedef logic [31:0] InstAddr;
  typedef logic [31:0] Inst;
  typedef logic [31:0] DataAddr;
  typedef logic [31:0] Data;
  typedef logic [4:0]  GPRAddr;
  typedef logic [1:0]  DataAccess;

  typedef enum logic {
    WRAP    = 1'b0,
    ONESHOT = 1'b1
  } TraceMode;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    STOPPED = 2'd3
  } TraceState;

  typedef struct packed {
    logic [TRACE_TICK_W-1:0] tick;
    InstAddr                 pc;
    Inst                     inst;
    logic                    regWr;
    GPRAddr                  regAddr;
    Data                     regData;
    logic                    memWr;
    DataAddr                 memAddr;
    DataAccess               memAccess;
    Data                     memData;
  } TraceEntry;

  localparam int TRACE_ENTRY_W = $bits(TraceEntry);

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO with optional overwrite-oldest on full and a
// synchronous flush. Only pointers and occupancy are reset; storage is not.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic                   overwrite,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_s;
  logic             empty_s;
  logic             do_read_s;
  logic             do_write_s;
  logic             pop_s;

  // Transfer decode; a write into a full FIFO with no read either drops the oldest or is refused
  always_comb begin
    full_s     = (count_r == CW'(DEPTH));
    empty_s    = (count_r == {CW{1'b0}});
    do_read_s  = rd_ready & ~empty_s;
    do_write_s = wr_en & (~full_s | do_read_s | overwrite);
    pop_s      = do_read_s | (wr_en & full_s & ~do_read_s & overwrite);
  end

  // Pointer and occupancy state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (clr) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_write_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_write_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage write port
  always_ff @(posedge clk) begin
    if (do_write_s && !clr) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  assign rd_valid = ~empty_s;
  assign rd_data  = mem_r[rd_ptr_r];
  assign count    = count_r;

endmodule

// File: rtl/debug_trace_buffer.sv
// Retire-trace capture: free-running tick, armed/PC-triggered capture FSM,
// halt detection and a FWFT record FIFO drained over a valid/ready port.
module debug_trace_buffer
  import debug_trace_buffer_pkg::*;
#(
  parameter int          DEPTH      = 16,
  parameter int          TICK_WIDTH = 32,
  parameter logic [31:0] HALT_INST  = 32'h0000006F
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_stall,
  output logic [TICK_WIDTH-1:0]  o_tick,
  input  logic [TICK_WIDTH-1:0]  i_tick,
  input  logic                   i_isValid,
  input  InstAddr                i_pc,
  input  Inst                    i_inst,
  input  GPRAddr                 i_regWrAddr,
  input  logic                   i_regWrEnable,
  input  Data                    i_regWrData,
  input  DataAddr                i_memWrAddr,
  input  logic                   i_memWrEnable,
  input  DataAccess              i_memAccess,
  input  Data                    i_memWrData,
  input  TraceMode               i_mode,
  input  logic                   i_arm,
  input  logic                   i_trigEnable,
  input  InstAddr                i_trigPc,
  input  logic                   i_stop,
  input  logic                   i_clear,
  output logic                   o_rdValid,
  input  logic                   i_rdReady,
  output TraceEntry              o_rdEntry,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow,
  output logic                   o_halted,
  output TraceState              o_state
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [TICK_WIDTH-1:0] tick_r;
  TraceState             state_r;
  TraceState             state_next_s;
  logic                  overflow_r;
  logic                  halted_r;
  logic                  halt_s;
  logic                  trig_hit_s;
  logic                  capture_s;
  logic                  full_s;
  logic                  do_read_s;
  logic                  blocked_s;
  logic                  wr_en_s;
  logic                  rd_valid_s;
  logic [CW-1:0]         count_s;
  TraceEntry             entry_s;
  TraceEntry             rd_data_s;

  // Free-running tick, frozen while the pipeline stalls
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      tick_r <= {TICK_WIDTH{1'b0}};
    end else if (!i_stall) begin
      tick_r <= tick_r + TICK_WIDTH'(1);
    end else begin
      tick_r <= tick_r;
    end
  end

  // Capture qualification; blocked_s marks a record arriving at a full FIFO with no read to make room
  always_comb begin
    halt_s     = i_isValid & (i_inst == HALT_INST);
    trig_hit_s = i_isValid & i_trigEnable & (i_pc == i_trigPc);
    full_s     = (count_s == CW'(DEPTH));
    do_read_s  = i_rdReady & rd_valid_s;
    case (state_r)
      CAPTURE: capture_s = i_isValid & ~i_clear;
      ARMED:   capture_s = trig_hit_s & ~i_clear;
      default: capture_s = 1'b0;
    endcase
    blocked_s = capture_s & full_s & ~do_read_s;
    if (i_mode == ONESHOT) begin
      wr_en_s = capture_s & ~blocked_s;
    end else begin
      wr_en_s = capture_s;
    end
  end

  // Record packing; register writes to x0 are not reported
  always_comb begin
    entry_s           = '0;
    entry_s.tick      = TRACE_TICK_W'(i_tick);
    entry_s.pc        = i_pc;
    entry_s.inst      = i_inst;
    entry_s.regWr     = i_regWrEnable & (i_regWrAddr != 5'd0);
    entry_s.regAddr   = i_regWrAddr;
    entry_s.regData   = i_regWrData;
    entry_s.memWr     = i_memWrEnable;
    entry_s.memAddr   = i_memWrAddr;
    entry_s.memAccess = i_memAccess;
    entry_s.memData   = i_memWrData;
  end

  // Capture FSM state register
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Capture FSM next state: clear, then stop/halt/oneshot-full, then arm
  always_comb begin
    state_next_s = state_r;
    if (i_clear) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_arm) begin
            state_next_s = ARMED;
          end else begin
            state_next_s = IDLE;
          end
        end
        ARMED: begin
          if (!i_trigEnable) begin
            state_next_s = CAPTURE;
          end else if (trig_hit_s) begin
            state_next_s = halt_s ? STOPPED : CAPTURE;
          end else begin
            state_next_s = ARMED;
          end
        end
        CAPTURE: begin
          if (i_stop || halt_s || (blocked_s && (i_mode == ONESHOT))) begin
            state_next_s = STOPPED;
          end else begin
            state_next_s = CAPTURE;
          end
        end
        STOPPED: state_next_s = STOPPED;
        default: state_next_s = IDLE;
      endcase
    end
  end

  // Sticky overflow and halt flags
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      overflow_r <= 1'b0;
      halted_r   <= 1'b0;
    end else if (i_clear) begin
      overflow_r <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      overflow_r <= overflow_r | blocked_s;
      halted_r   <= halted_r | halt_s;
    end
  end

  trace_fifo #(
    .WIDTH (TRACE_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (i_clock),
    .rst_n     (i_reset),
    .clr       (i_clear),
    .wr_en     (wr_en_s),
    .overwrite (i_mode == WRAP),
    .wr_data   (entry_s),
    .rd_ready  (i_rdReady),
    .rd_valid  (rd_valid_s),
    .rd_data   (rd_data_s),
    .count     (count_s)
  );

  assign o_tick     = tick_r;
  assign o_rdValid  = rd_valid_s;
  assign o_rdEntry  = rd_data_s;
  assign o_count    = count_s;
  assign o_overflow = overflow_r;
  assign o_halted   = halted_r;
  assign o_state    = state_r;

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Directed self-checking bench for debug_trace_buffer (DEPTH=4).
module tb_debug_trace_buffer;
  import debug_trace_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] tick_o;
  logic [31:0] tick_i = 32'd0;
  logic        is_valid = 1'b0;
  InstAddr     pc = 32'd0;
  Inst         inst = 32'd0;
  GPRAddr      reg_addr = 5'd0;
  logic        reg_en = 1'b0;
  Data         reg_data = 32'd0;
  DataAddr     mem_addr = 32'd0;
  logic        mem_en = 1'b0;
  DataAccess   mem_acc = 2'd0;
  Data         mem_data = 32'd0;
  TraceMode    mode = WRAP;
  logic        arm = 1'b0;
  logic        trig_en = 1'b0;
  InstAddr     trig_pc = 32'd0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  TraceEntry   rd_entry;
  logic [2:0]  count;
  logic        overflow;
  logic        halted;
  TraceState   state;

  int n_checks = 0;
  int n_fail = 0;

  debug_trace_buffer #(.DEPTH(4), .TICK_WIDTH(32), .HALT_INST(32'h0000006F)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_stall(stall), .o_tick(tick_o), .i_tick(tick_i),
    .i_isValid(is_valid), .i_pc(pc), .i_inst(inst), .i_regWrAddr(reg_addr),
    .i_regWrEnable(reg_en), .i_regWrData(reg_data), .i_memWrAddr(mem_addr),
    .i_memWrEnable(mem_en), .i_memAccess(mem_acc), .i_memWrData(mem_data), .i_mode(mode),
    .i_arm(arm), .i_trigEnable(trig_en), .i_trigPc(trig_pc), .i_stop(stop), .i_clear(clear),
    .o_rdValid(rd_valid), .i_rdReady(rd_ready), .o_rdEntry(rd_entry), .o_count(count),
    .o_overflow(overflow), .o_halted(halted), .o_state(state)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] p, input logic [31:0] ins, input logic [31:0] tk,
                        input logic [4:0] ra, input logic re);
    is_valid = 1'b1; pc = p; inst = ins; tick_i = tk; reg_addr = ra; reg_en = re;
    reg_data = tk + 32'h1000;
  endtask

  task automatic idle_bus();
    is_valid = 1'b0; reg_en = 1'b0; mem_en = 1'b0;
  endtask

  task automatic start_capture(input TraceMode m);
    clear = 1'b1; cyc(); clear = 1'b0;
    mode = m; trig_en = 1'b0;
    arm = 1'b1; cyc(); arm = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (tick_o !== 32'd0) begin n_fail++; $display("FAIL reset_tick: got %0d expected 0", tick_o); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rdvalid: got %0b expected 0", rd_valid); end
    n_checks++; if ({overflow, halted} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %0b%0b expected 00", overflow, halted); end
    n_checks++; if (state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", state, IDLE); end
  endtask

  task automatic test_tick();
    rst_n = 1'b1;
    repeat (5) cyc();
    n_checks++; if (tick_o !== 32'd5) begin n_fail++; $display("FAIL tick_free: got %0d expected 5", tick_o); end
    stall = 1'b1;
    repeat (3) cyc();
    n_checks++; if (tick_o !== 32'd5) begin n_fail++; $display("FAIL tick_stall: got %0d expected 5", tick_o); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (tick_o !== 32'd0) begin n_fail++; $display("FAIL tick_async_reset: got %0d expected 0", tick_o); end
    stall = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_trigger();
    mode = WRAP; trig_en = 1'b1; trig_pc = 32'h100;
    arm = 1'b1; cyc(); arm = 1'b0;
    n_checks++; if (state !== ARMED) begin n_fail++; $display("FAIL trig_armed: got %0d expected %0d", state, ARMED); end
    retire(32'hF8, 32'h13, 32'd1, 5'd3, 1'b1); cyc();
    retire(32'hFC, 32'h13, 32'd2, 5'd3, 1'b1); cyc();
    retire(32'h100, 32'h13, 32'd3, 5'd0, 1'b1); cyc();
    retire(32'h104, 32'h13, 32'd4, 5'd5, 1'b1);
    mem_en = 1'b1; mem_addr = 32'h8000; mem_data = 32'hCAFE; mem_acc = 2'd2;
    cyc();
    idle_bus();
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL trig_count: got %0d expected 2", count); end
    n_checks++; if (state !== CAPTURE) begin n_fail++; $display("FAIL trig_state: got %0d expected %0d", state, CAPTURE); end
    n_checks++; if (rd_entry.pc !== 32'h100) begin n_fail++; $display("FAIL trig_first_pc: got %0h expected 100", rd_entry.pc); end
    n_checks++; if (rd_entry.regWr !== 1'b0) begin n_fail++; $display("FAIL trig_x0_regwr: got %0b expected 0", rd_entry.regWr); end
    rd_ready = 1'b1; cyc(); rd_ready = 1'b0;
    n_checks++; if (rd_entry.pc !== 32'h104) begin n_fail++; $display("FAIL trig_second_pc: got %0h expected 104", rd_entry.pc); end
    n_checks++; if ({rd_entry.regWr, rd_entry.regAddr} !== {1'b1, 5'd5}) begin n_fail++; $display("FAIL trig_second_reg: got %0b/%0d expected 1/5", rd_entry.regWr, rd_entry.regAddr); end
    n_checks++; if ({rd_entry.memWr, rd_entry.memData, rd_entry.memAccess} !== {1'b1, 32'hCAFE, 2'd2}) begin n_fail++; $display("FAIL trig_second_mem: got %0b/%0h/%0d expected 1/cafe/2", rd_entry.memWr, rd_entry.memData, rd_entry.memAccess); end
    rd_ready = 1'b1; cyc(); rd_ready = 1'b0;
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL trig_drained: got %0b expected 0", rd_valid); end
    retire(32'h108, 32'h13, 32'd5, 5'd1, 1'b1); stop = 1'b1; cyc(); stop = 1'b0; idle_bus();
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL stop_record_kept: got %0d expected 1", count); end
    n_checks++; if (state !== STOPPED) begin n_fail++; $display("FAIL stop_state: got %0d expected %0d", state, STOPPED); end
    trig_en = 1'b0;
  endtask

  task automatic test_wrap();
    start_capture(WRAP);
    n_checks++; if (state !== CAPTURE) begin n_fail++; $display("FAIL wrap_state: got %0d expected %0d", state, CAPTURE); end
    for (int i = 1; i <= 6; i++) begin
      retire(32'h200 + 32'(4 * i), 32'h13, 32'(i), 5'd1, 1'b1); cyc();
    end
    idle_bus();
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL wrap_count: got %0d expected 4", count); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL wrap_overflow: got %0b expected 1", overflow); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (rd_entry.tick !== 32'(3 + i)) begin n_fail++; $display("FAIL wrap_drain_tick: got %0d expected %0d", rd_entry.tick, 3 + i); end
      rd_ready = 1'b1; cyc(); rd_ready = 1'b0;
    end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_empty: got %0b expected 0", rd_valid); end
  endtask

  task automatic test_oneshot();
    start_capture(ONESHOT);
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clear_overflow: got %0b expected 0", overflow); end
    for (int i = 1; i <= 4; i++) begin
      retire(32'h300 + 32'(4 * i), 32'h13, 32'(i), 5'd2, 1'b1); cyc();
    end
    n_checks++; if ({count, state} !== {3'd4, CAPTURE}) begin n_fail++; $display("FAIL oneshot_full: got %0d/%0d expected 4/%0d", count, state, CAPTURE); end
    n_checks++; if (rd_entry.tick !== 32'd1) begin n_fail++; $display("FAIL oneshot_head: got %0d expected 1", rd_entry.tick); end
    retire(32'h314, 32'h13, 32'd5, 5'd2, 1'b1); rd_ready = 1'b1; cyc(); rd_ready = 1'b0;
    n_checks++; if ({count, overflow} !== {3'd4, 1'b0}) begin n_fail++; $display("FAIL oneshot_rdwr: got %0d/%0b expected 4/0", count, overflow); end
    n_checks++; if (state !== CAPTURE) begin n_fail++; $display("FAIL oneshot_rdwr_state: got %0d expected %0d", state, CAPTURE); end
    retire(32'h318, 32'h13, 32'd6, 5'd2, 1'b1); cyc(); idle_bus();
    n_checks++; if ({count, overflow} !== {3'd4, 1'b1}) begin n_fail++; $display("FAIL oneshot_drop: got %0d/%0b expected 4/1", count, overflow); end
    n_checks++; if (state !== STOPPED) begin n_fail++; $display("FAIL oneshot_stop: got %0d expected %0d", state, STOPPED); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (rd_entry.tick !== 32'(2 + i)) begin n_fail++; $display("FAIL oneshot_drain_tick: got %0d expected %0d", rd_entry.tick, 2 + i); end
      rd_ready = 1'b1; cyc(); rd_ready = 1'b0;
    end
  endtask

  task automatic test_halt();
    start_capture(WRAP);
    retire(32'h400, 32'h13, 32'd10, 5'd1, 1'b1); cyc();
    retire(32'h404, 32'h6F, 32'd11, 5'd0, 1'b0); cyc();
    retire(32'h408, 32'h13, 32'd12, 5'd1, 1'b1); cyc();
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL halt_count: got %0d expected 2", count); end
    n_checks++; if ({halted, state} !== {1'b1, STOPPED}) begin n_fail++; $display("FAIL halt_stop: got %0b/%0d expected 1/%0d", halted, state, STOPPED); end
    retire(32'h40C, 32'h6F, 32'd13, 5'd0, 1'b0); clear = 1'b1; cyc(); clear = 1'b0; idle_bus();
    n_checks++; if ({count, rd_valid} !== {3'd0, 1'b0}) begin n_fail++; $display("FAIL clear_fifo: got %0d/%0b expected 0/0", count, rd_valid); end
    n_checks++; if ({overflow, halted} !== 2'b00) begin n_fail++; $display("FAIL clear_flags: got %0b%0b expected 00", overflow, halted); end
    n_checks++; if (state !== IDLE) begin n_fail++; $display("FAIL clear_state: got %0d expected %0d", state, IDLE); end
  endtask

  task automatic test_backpressure();
    start_capture(WRAP);
    for (int i = 0; i < 3; i++) begin
      retire(32'h500 + 32'(4 * i), 32'h13, 32'(21 + i), 5'd1, 1'b1); cyc();
    end
    idle_bus();
    n_checks++; if ({count, rd_entry.tick} !== {3'd3, 32'd21}) begin n_fail++; $display("FAIL bp_head: got %0d/%0d expected 3/21", count, rd_entry.tick); end
    rd_ready = 1'b1; cyc();
    n_checks++; if (rd_entry.tick !== 32'd22) begin n_fail++; $display("FAIL bp_read1: got %0d expected 22", rd_entry.tick); end
    rd_ready = 1'b0; cyc();
    n_checks++; if ({count, rd_entry.tick} !== {3'd2, 32'd22}) begin n_fail++; $display("FAIL bp_hold: got %0d/%0d expected 2/22", count, rd_entry.tick); end
    rd_ready = 1'b1; cyc();
    n_checks++; if (rd_entry.tick !== 32'd23) begin n_fail++; $display("FAIL bp_read2: got %0d expected 23", rd_entry.tick); end
    cyc(); rd_ready = 1'b0;
    n_checks++; if ({count, rd_valid} !== {3'd0, 1'b0}) begin n_fail++; $display("FAIL bp_empty: got %0d/%0b expected 0/0", count, rd_valid); end
  endtask

  task automatic test_back_to_back();
    start_capture(WRAP);
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      retire(32'h600 + 32'(4 * i), 32'h13, 32'(31 + i), 5'd1, 1'b1); cyc();
      n_checks++; if ({count, rd_valid, rd_entry.tick} !== {3'd1, 1'b1, 32'(31 + i)}) begin n_fail++; $display("FAIL b2b_stream: got %0d/%0b/%0d expected 1/1/%0d", count, rd_valid, rd_entry.tick, 31 + i); end
    end
    idle_bus(); cyc(); rd_ready = 1'b0;
    n_checks++; if ({count, rd_valid} !== {3'd0, 1'b0}) begin n_fail++; $display("FAIL b2b_drain: got %0d/%0b expected 0/0", count, rd_valid); end
  endtask

  task automatic test_reset_mid();
    start_capture(WRAP);
    retire(32'h700, 32'h6F, 32'd40, 5'd1, 1'b1); cyc();
    retire(32'h704, 32'h13, 32'd41, 5'd1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({count, rd_valid, halted} !== {3'd0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL rst_mid_fifo: got %0d/%0b/%0b expected 0/0/0", count, rd_valid, halted); end
    n_checks++; if (state !== IDLE) begin n_fail++; $display("FAIL rst_mid_state: got %0d expected %0d", state, IDLE); end
    idle_bus(); cyc(); rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_tick();
    test_trigger();
    test_wrap();
    test_oneshot();
    test_halt();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
